pmem_arbiter: RTL and testbench

- Sits directly downstream of the instruction cache and the data cache.
- Multiplexes their line-granular physical-memory requests onto the single physical memory port.
- The I-cache side is read-only; the D-cache side does line fills (read) and writebacks (write).
- Each grant latches one whole transaction and holds it stable until pmem_resp. Arbitration is round-robin when both sides are pending.

---
 rtl/pmem_arbiter.sv | 141 ++++++++++++++
 tb/tb_pmem_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmem_arbiter.sv
// Physical-memory arbiter between the I-cache and D-cache. Each grant latches one
// complete line transaction and holds it stable on the pmem port until pmem_resp.
module pmem_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int LINE_W      = 128,
  parameter int OFFSET_BITS = 4
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,

  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,

  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BUSY_I = 2'd1,
    S_BUSY_D = 2'd2
  } state_t;

  typedef enum logic {
    SIDE_I = 1'b0,
    SIDE_D = 1'b1
  } side_t;

  localparam logic [ADDR_W-1:0] ADDR_MASK =
    {{(ADDR_W-OFFSET_BITS){1'b1}}, {OFFSET_BITS{1'b0}}};

  state_t            r_state;
  state_t            w_state_next;
  side_t             r_last_grant;
  logic              r_op_write;
  logic [ADDR_W-1:0] r_addr;
  logic [LINE_W-1:0] r_wdata;

  logic              w_i_req;
  logic              w_d_req;
  logic              w_grant_i;
  logic              w_grant_d;
  logic              w_latch_wdata;
  logic [ADDR_W-1:0] w_req_addr;

  assign w_i_req = i_pmem_read;
  assign w_d_req = d_pmem_read | d_pmem_write;

  // On a tie the side that did not win last time gets the grant (round-robin).
  assign w_grant_d = (r_state == S_IDLE) && w_d_req &&
                     (!w_i_req || (r_last_grant == SIDE_I));
  assign w_grant_i = (r_state == S_IDLE) && w_i_req && !w_grant_d;

  // A D request with both read and write high is taken as a writeback.
  assign w_latch_wdata = w_grant_d && d_pmem_write;
  assign w_req_addr    = w_grant_d ? d_pmem_address : i_pmem_address;

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    w_state_next = r_state;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    i_pmem_resp  = 1'b0;
    d_pmem_resp  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_grant_d) begin
          w_state_next = S_BUSY_D;
        end else if (w_grant_i) begin
          w_state_next = S_BUSY_I;
        end
      end
      S_BUSY_I: begin
        pmem_read  = !r_op_write;
        pmem_write = r_op_write;
        if (pmem_resp) begin
          i_pmem_resp  = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      S_BUSY_D: begin
        pmem_read  = !r_op_write;
        pmem_write = r_op_write;
        if (pmem_resp) begin
          d_pmem_resp  = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // NOTE: the wide line register is reset too, because pmem_wdata must read zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= SIDE_I;
      r_op_write   <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
    end else if (w_grant_d || w_grant_i) begin
      r_last_grant <= w_grant_d ? SIDE_D : SIDE_I;
      r_op_write   <= w_latch_wdata;
      r_addr       <= w_req_addr & ADDR_MASK;
      if (w_latch_wdata) begin
        r_wdata <= d_pmem_wdata;
      end
    end
  end

  assign pmem_address = r_addr;
  assign pmem_wdata   = r_wdata;

  // Read data fans out to both clients; only the resp strobes are steered.
  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Self-checking bench for pmem_arbiter: directed vector table, hand-written
// multi-cycle sequences, and randomized traffic against a transaction-level model.
module tb_pmem_arbiter;

  localparam int ADDR_W = 16;
  localparam int LINE_W = 128;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              i_pmem_read;
  logic [ADDR_W-1:0] i_pmem_address;
  logic [LINE_W-1:0] i_pmem_rdata;
  logic              i_pmem_resp;
  logic              d_pmem_read;
  logic              d_pmem_write;
  logic [ADDR_W-1:0] d_pmem_address;
  logic [LINE_W-1:0] d_pmem_wdata;
  logic [LINE_W-1:0] d_pmem_rdata;
  logic              d_pmem_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  int n_tests = 0;
  int n_fail  = 0;

  pmem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .OFFSET_BITS(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] PAT_A5 = {16{8'hA5}};
  localparam logic [127:0] PAT_5A = {16{8'h5A}};
  localparam logic [127:0] PAT_RD = 128'hC0DE_0001_C0DE_0002_C0DE_0003_C0DE_0004;

  typedef struct {
    bit           rst;
    bit           i_rd;
    logic [15:0]  i_addr;
    bit           d_rd;
    bit           d_wr;
    logic [15:0]  d_addr;
    logic [127:0] d_wdata;
    bit           resp;
    logic [127:0] rdata;
    bit           e_rd;
    bit           e_wr;
    logic [15:0]  e_addr;
    logic [127:0] e_wdata;
    bit           e_iresp;
    bit           e_dresp;
  } vec_t;

  // Transaction-level reference: one optional outstanding transaction plus who won last.
  typedef struct {
    bit           busy;
    bit           side_d;
    bit           write;
    logic [15:0]  addr;
    logic [127:0] wdata;
    bit           last_d;
  } model_t;

  model_t m;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag, input bit e_rd, input bit e_wr,
                               input logic [15:0] e_addr, input logic [127:0] e_wdata,
                               input bit e_iresp, input bit e_dresp);
    check({tag, ".pmem_read"},    128'(pmem_read),    128'(e_rd));
    check({tag, ".pmem_write"},   128'(pmem_write),   128'(e_wr));
    check({tag, ".pmem_address"}, 128'(pmem_address), 128'(e_addr));
    check({tag, ".pmem_wdata"},   pmem_wdata,         e_wdata);
    check({tag, ".i_pmem_resp"},  128'(i_pmem_resp),  128'(e_iresp));
    check({tag, ".d_pmem_resp"},  128'(d_pmem_resp),  128'(e_dresp));
    check({tag, ".i_pmem_rdata"}, i_pmem_rdata,       pmem_rdata);
    check({tag, ".d_pmem_rdata"}, d_pmem_rdata,       pmem_rdata);
  endtask

  task automatic idle_inputs();
    i_pmem_read    = 1'b0;
    i_pmem_address = '0;
    d_pmem_read    = 1'b0;
    d_pmem_write   = 1'b0;
    d_pmem_address = '0;
    d_pmem_wdata   = '0;
    pmem_resp      = 1'b0;
    pmem_rdata     = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Waits (bounded) for a strobe; returns with the sample taken #1 after a negedge.
  task automatic wait_strobe(input string name, output bit found);
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (pmem_read || pmem_write) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!found) check({name, ".timeout"}, 128'd0, 128'd1);
  endtask

  function automatic logic [15:0] line_addr(input logic [15:0] a);
    return {a[15:4], 4'h0};
  endfunction

  vec_t vecs[$];

  function automatic vec_t mk(input bit rst, input bit i_rd, input logic [15:0] i_addr,
                              input bit d_rd, input bit d_wr, input logic [15:0] d_addr,
                              input logic [127:0] d_wdata, input bit resp,
                              input logic [127:0] rdata, input bit e_rd, input bit e_wr,
                              input logic [15:0] e_addr, input logic [127:0] e_wdata,
                              input bit e_iresp, input bit e_dresp);
    vec_t v;
    v.rst = rst; v.i_rd = i_rd; v.i_addr = i_addr; v.d_rd = d_rd; v.d_wr = d_wr;
    v.d_addr = d_addr; v.d_wdata = d_wdata; v.resp = resp; v.rdata = rdata;
    v.e_rd = e_rd; v.e_wr = e_wr; v.e_addr = e_addr; v.e_wdata = e_wdata;
    v.e_iresp = e_iresp; v.e_dresp = e_dresp;
    return v;
  endfunction

  initial begin
    bit found;
    rst_n = 1'b0;
    idle_inputs();

    // ---------------- directed vector table (one row per cycle) ----------------
    vecs.push_back(mk(1, 0, 16'h0, 0, 0, 16'h0,    '0,     0, '0,     0, 0, 16'h0,    '0,     0, 0));
    vecs.push_back(mk(0, 0, 16'h0, 1, 0, 16'h1234, '0,     0, '0,     0, 0, 16'h0,    '0,     0, 0));
    for (int k = 0; k < 5; k++)
      vecs.push_back(mk(0, 0, 16'h0, 1, 0, 16'h1234, '0,   0, '0,     1, 0, 16'h1230, '0,     0, 0));
    vecs.push_back(mk(0, 0, 16'h0, 1, 0, 16'h1234, '0,     1, PAT_RD, 1, 0, 16'h1230, '0,     0, 1));
    vecs.push_back(mk(0, 0, 16'h0, 0, 0, 16'h0,    '0,     1, PAT_RD, 0, 0, 16'h1230, '0,     0, 0));
    vecs.push_back(mk(1, 0, 16'h0, 0, 0, 16'h0,    '0,     0, '0,     0, 0, 16'h0,    '0,     0, 0));
    vecs.push_back(mk(0, 1, 16'h0040, 0, 1, 16'h8000, PAT_A5, 0, '0,  0, 0, 16'h0,    '0,     0, 0));
    vecs.push_back(mk(0, 1, 16'h0040, 0, 1, 16'h8000, PAT_A5, 0, '0,  0, 1, 16'h8000, PAT_A5, 0, 0));
    vecs.push_back(mk(0, 1, 16'h0040, 0, 1, 16'h9000, PAT_5A, 0, '0,  0, 1, 16'h8000, PAT_A5, 0, 0));
    vecs.push_back(mk(0, 1, 16'h0040, 0, 1, 16'h9000, PAT_5A, 1, '0,  0, 1, 16'h8000, PAT_A5, 0, 1));
    vecs.push_back(mk(0, 1, 16'h0040, 0, 0, 16'h0,    '0,     0, '0,  0, 0, 16'h8000, PAT_A5, 0, 0));
    vecs.push_back(mk(0, 1, 16'h0040, 0, 0, 16'h0,    '0,     0, '0,  1, 0, 16'h0040, PAT_A5, 0, 0));
    vecs.push_back(mk(0, 0, 16'h0,    0, 0, 16'h0,    '0,     1, PAT_RD, 1, 0, 16'h0040, PAT_A5, 1, 0));
    vecs.push_back(mk(0, 0, 16'h0,    1, 1, 16'h2345, PAT_5A, 0, '0,  0, 0, 16'h0040, PAT_A5, 0, 0));
    vecs.push_back(mk(0, 0, 16'h0,    1, 1, 16'h2345, PAT_5A, 0, '0,  0, 1, 16'h2340, PAT_5A, 0, 0));
    vecs.push_back(mk(0, 0, 16'h0,    1, 1, 16'h2345, PAT_5A, 1, PAT_RD, 0, 1, 16'h2340, PAT_5A, 0, 1));
    vecs.push_back(mk(0, 0, 16'h0,    0, 0, 16'h0,    '0,     0, '0,  0, 0, 16'h2340, PAT_5A, 0, 0));

    foreach (vecs[i]) begin
      @(negedge clk);
      rst_n          = !vecs[i].rst;
      i_pmem_read    = vecs[i].i_rd;
      i_pmem_address = vecs[i].i_addr;
      d_pmem_read    = vecs[i].d_rd;
      d_pmem_write   = vecs[i].d_wr;
      d_pmem_address = vecs[i].d_addr;
      d_pmem_wdata   = vecs[i].d_wdata;
      pmem_resp      = vecs[i].resp;
      pmem_rdata     = vecs[i].rdata;
      #1;
      check_outputs($sformatf("vec%0d", i), vecs[i].e_rd, vecs[i].e_wr, vecs[i].e_addr,
                    vecs[i].e_wdata, vecs[i].e_iresp, vecs[i].e_dresp);
    end

    // ---------------- async reset while BUSY_I with D pending ----------------
    do_reset();
    i_pmem_read    = 1'b1;
    i_pmem_address = 16'h0ABC;
    @(negedge clk);
    d_pmem_read    = 1'b1;
    d_pmem_address = 16'h4567;
    #1;
    check("rst_mid.busy_i_read", 128'(pmem_read), 128'd1);
    check("rst_mid.busy_i_addr", 128'(pmem_address), 128'h0AB0);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid.read_drop", 128'(pmem_read), 128'd0);
    check("rst_mid.addr_clear", 128'(pmem_address), 128'd0);
    check("rst_mid.no_iresp", 128'(i_pmem_resp), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("rst_mid.d_granted_read", 128'(pmem_read), 128'd1);
    check("rst_mid.d_granted_addr", 128'(pmem_address), 128'h4560);
    pmem_resp = 1'b1;
    #1;
    check("rst_mid.dresp", 128'(d_pmem_resp), 128'd1);
    check("rst_mid.no_iresp2", 128'(i_pmem_resp), 128'd0);
    @(negedge clk);
    pmem_resp = 1'b0;

    // ---------------- strict alternation with both sides held ----------------
    do_reset();
    i_pmem_read    = 1'b1;
    i_pmem_address = 16'h0105;
    d_pmem_read    = 1'b1;
    d_pmem_address = 16'h0207;
    for (int t = 0; t < 6; t++) begin
      bit exp_d;
      exp_d = (t % 2 == 0);
      wait_strobe($sformatf("alt%0d", t), found);
      if (found) begin
        check($sformatf("alt%0d.addr", t), 128'(pmem_address),
              exp_d ? 128'h0200 : 128'h0100);
        pmem_resp = 1'b1;
        #1;
        check($sformatf("alt%0d.iresp", t), 128'(i_pmem_resp), 128'(!exp_d));
        check($sformatf("alt%0d.dresp", t), 128'(d_pmem_resp), 128'(exp_d));
        @(negedge clk);
        pmem_resp = 1'b0;
        #1;
        check($sformatf("alt%0d.gap", t), 128'(pmem_read | pmem_write), 128'd0);
        @(negedge clk);
      end
    end

    // ---------------- randomized traffic against the reference model ----------------
    do_reset();
    m = '{busy: 1'b0, side_d: 1'b0, write: 1'b0, addr: '0, wdata: '0, last_d: 1'b0};
    for (int cyc = 0; cyc < 600; cyc++) begin
      bit ireq, dreq, pick_d;
      i_pmem_read    = ($urandom_range(0, 1) == 1);
      i_pmem_address = 16'($urandom);
      d_pmem_read    = ($urandom_range(0, 3) == 0);
      d_pmem_write   = ($urandom_range(0, 3) == 0);
      d_pmem_address = 16'($urandom);
      d_pmem_wdata   = {$urandom, $urandom, $urandom, $urandom};
      pmem_resp      = ($urandom_range(0, 9) < 3);
      pmem_rdata     = {$urandom, $urandom, $urandom, $urandom};
      #1;
      check_outputs($sformatf("rnd%0d", cyc),
                    m.busy && !m.write, m.busy && m.write, m.addr, m.wdata,
                    m.busy && !m.side_d && pmem_resp, m.busy && m.side_d && pmem_resp);
      // Advance the model to the state that follows this cycle's clock edge.
      if (m.busy) begin
        if (pmem_resp) m.busy = 1'b0;
      end else begin
        ireq = i_pmem_read;
        dreq = d_pmem_read || d_pmem_write;
        if (ireq || dreq) begin
          pick_d   = (dreq && ireq) ? !m.last_d : dreq;
          m.busy   = 1'b1;
          m.side_d = pick_d;
          m.last_d = pick_d;
          m.write  = pick_d && d_pmem_write;
          m.addr   = line_addr(pick_d ? d_pmem_address : i_pmem_address);
          if (m.write) m.wdata = d_pmem_wdata;
        end
      end
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
